hazard_ctrl_mw: RTL and testbench
=================================

// Module: hazard_ctrl_mw
// PURPOSE
// - Parametrised hazard/forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
// - Adds variable-latency data-memory handshake (mem_ready), wait timeout with sticky error, x0 and unused-source filtering.
// - Fixes branch vs load-use priority. Drives the stall/flush inputs of the stage registers and the EX operand forwarding muxes.
// PARAMETERS
// - REG_AW    5    register address width (2**REG_AW architectural registers)
// - WAIT_MAX  255  maximum consecutive memory wait cycles before timeout (1..65535)
// - CNT_W     32   width of performance counters (only with HZD_PERF_CNT_EN)
// PORTS
// - clk         in   1       clock, rising edge
// - rst         in   1       reset, asynchronous, active-high
// - rs1_d/rs2_d in   REG_AW  source regs of instruction in ID
// - rs1_use_d/rs2_use_d in 1 ID instruction actually reads rs1/rs2
// - rs1_e/rs2_e in   REG_AW  source regs of instruction in EX
// - rd_e/rd_m/rd_w in REG_AW dest regs in EX/MEM/WB
// - reg_write_e/_m/_w in 1  dest write enable per stage
// - is_load_e   in   1       EX instruction is a load
// - pc_src_e    in   1       branch taken / jump resolved in EX
// - mreq_m      in   1       MEM stage issues data access this cycle
// - mem_ready   in   1       data memory completes access this cycle
// - fwd_rs1_e/fwd_rs2_e out 2 00 reg file, 10 MEM alu_out, 01 WB result
// - stall_f/stall_d/stall_e/stall_m out 1 hold PC / IF-ID / ID-EX / EX-MEM regs
// - flush_d/flush_e/flush_w out 1 bubble into IF-ID / ID-EX / MEM-WB regs
// - mem_err     out  1       sticky timeout error
// BEHAVIOUR
// - Forward (comb.): rs_e==rd_m & reg_write_m & rd_m!=0 -> 10; else rs_e==rd_w & reg_write_w & rd_w!=0 -> 01; else 00. MEM beats WB.
// - Load-use (lu): is_load_e & reg_write_e & rd_e!=0 & ((rs1_use_d & rs1_d==rd_e) | (rs2_use_d & rs2_d==rd_e)).
// - mw = mreq_m & ~mem_ready (memory wait, same cycle as request; no added latency when mem_ready=1).
// - Priority, highest first:
//   1 ERR state: stall_f..stall_m=1, flush_w=1, all other flushes 0.
//   2 mw: stall_f..stall_m=1, flush_w=1; pc_src_e and lu ignored (EX frozen, resolved after release).
//   3 pc_src_e: flush_d=1, flush_e=1, stalls 0; lu suppressed (ID instr is killed).
//   4 lu: stall_f=1, stall_d=1, flush_e=1.
//   5 else all stall/flush 0.
// - FSM (registered): IDLE -> WAIT on mw; WAIT stays while mw, wcnt++;
//   WAIT -> IDLE when mem_ready or ~mreq_m (cnt cleared); WAIT -> ERR when wcnt reaches WAIT_MAX with mw.
//   ERR held until rst; mem_err=1 in ERR.
// - wcnt width $clog2(WAIT_MAX+1), saturates, never wraps.
// - Reset: state IDLE, wcnt=0, mem_err=0, counters 0; comb. outputs follow the rules above with state=IDLE.
// - Reset mid-wait aborts to IDLE immediately (async); no pending state retained.
// - rd=0 never forwards or causes load-use stall.
// CONFIGURATION
// - HZD_PERF_CNT_EN defined: adds outputs cnt_lu, cnt_mw, cnt_flush [CNT_W-1:0].
//   Each counts cycles where priority rule 4, 2 or 3 respectively is active; saturating at all-ones; cleared by rst.
// - Not defined: no counter ports or logic; all other behaviour identical.
// TESTING
// - rst=1 then release, all inputs 0 -> all stalls/flushes 0, fwd 00, mem_err 0.
// - rs1_e=5, rd_m=5, reg_write_m=1, rd_w=5, reg_write_w=1 -> fwd_rs1_e=10; rd_m=0 instead -> 01; rd_w=0 too -> 00.
// - Load-use: is_load_e=1, rd_e=7, reg_write_e=1, rs2_d=7, rs2_use_d=1 -> stall_f=stall_d=flush_e=1 one cycle;
//   same with rs2_use_d=0 -> no stall.
// - Load-use plus pc_src_e=1 same cycle -> flush_d=flush_e=1, stall_f=stall_d=0.
// - mreq_m=1, mem_ready=0 for 3 cycles then 1, pc_src_e=1 throughout -> stalls+flush_w for 3 cycles,
//   4th cycle flush_d=flush_e=1, state IDLE.
// - WAIT_MAX=4, mreq_m=1, mem_ready=0 held -> mem_err=1 after 5th wait cycle; stays 1 until rst; async rst mid-ERR clears it.

Source files
------------

// File: rtl/hazard_ctrl_mw_if.sv
// Pipeline hazard bundle: ID/EX/MEM/WB register info and memory handshake in,
// stall/flush/forward controls and the sticky memory error out.
interface hazard_ctrl_mw_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              rs1_use_d, rs2_use_d;
  logic              reg_write_e, reg_write_m, reg_write_w;
  logic              is_load_e, pc_src_e, mreq_m, mem_ready;
  logic [1:0]        fwd_rs1_e, fwd_rs2_e;
  logic              stall_f, stall_d, stall_e, stall_m;
  logic              flush_d, flush_e, flush_w;
  logic              mem_err;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           rs1_use_d, rs2_use_d, reg_write_e, reg_write_m, reg_write_w,
           is_load_e, pc_src_e, mreq_m, mem_ready,
    input  fwd_rs1_e, fwd_rs2_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_err
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
           rs1_use_d, rs2_use_d, reg_write_e, reg_write_m, reg_write_w,
           is_load_e, pc_src_e, mreq_m, mem_ready,
    output fwd_rs1_e, fwd_rs2_e, stall_f, stall_d, stall_e, stall_m,
           flush_d, flush_e, flush_w, mem_err
  );
endinterface

// File: rtl/hazard_ctrl_mw.sv
// Hazard/forwarding controller for a 5-stage RV32I pipeline with memory-wait timeout.
// Optional macro HZD_PERF_CNT_EN adds saturating cnt_lu / cnt_mw / cnt_flush counters.
//
// state | meaning
// IDLE  | no memory wait outstanding
// WAIT  | MEM access stalled, wcnt counts consecutive wait cycles
// ERR   | wait exceeded WAIT_MAX; pipeline frozen until rst
module hazard_ctrl_mw #(
  parameter int REG_AW   = 5,
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 32
) (
  input  logic clk,
  input  logic rst,
  hazard_ctrl_mw_if.slave hz
`ifdef HZD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_lu,
  output logic [CNT_W-1:0] cnt_mw,
  output logic [CNT_W-1:0] cnt_flush
`endif
);

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [REG_AW-1:0] X0 = '0;

  if (WAIT_MAX < 1 || WAIT_MAX > 65535 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl_mw: WAIT_MAX must be 1..65535 and CNT_W >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              mem_err_q, mem_err_d;
  logic              lu, mw, r_err, r_mw, r_br, r_lu, freeze;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                         input logic [REG_AW-1:0] rd_m,
                                         input logic              we_m,
                                         input logic [REG_AW-1:0] rd_w,
                                         input logic              we_w);
    if (we_m && rd_m != X0 && rs == rd_m)      return 2'b10;
    else if (we_w && rd_w != X0 && rs == rd_w) return 2'b01;
    else                                       return 2'b00;
  endfunction

  always_comb begin
    hz.fwd_rs1_e = fwd_sel(hz.rs1_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);
    hz.fwd_rs2_e = fwd_sel(hz.rs2_e, hz.rd_m, hz.reg_write_m, hz.rd_w, hz.reg_write_w);

    lu = hz.is_load_e && hz.reg_write_e && hz.rd_e != X0 &&
         ((hz.rs1_use_d && hz.rs1_d == hz.rd_e) || (hz.rs2_use_d && hz.rs2_d == hz.rd_e));
    mw = hz.mreq_m && !hz.mem_ready;

    // Priority chain: error, memory wait, taken branch, load-use.
    r_err  = (state_q == ERR);
    r_mw   = !r_err && mw;
    r_br   = !r_err && !mw && hz.pc_src_e;
    r_lu   = !r_err && !mw && !hz.pc_src_e && lu;
    freeze = r_err || r_mw;

    hz.stall_f = freeze || r_lu;
    hz.stall_d = freeze || r_lu;
    hz.stall_e = freeze;
    hz.stall_m = freeze;
    hz.flush_d = r_br;
    hz.flush_e = r_br || r_lu;
    hz.flush_w = freeze;
    hz.mem_err = mem_err_q;

    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: if (mw) begin
        state_d = WAIT;
        wcnt_d  = WCNT_W'(1);
      end
      WAIT: if (!mw) begin
        state_d = IDLE;
        wcnt_d  = '0;
      end else if (wcnt_q == WCNT_W'(WAIT_MAX)) begin
        state_d = ERR;
      end else begin
        wcnt_d = wcnt_q + WCNT_W'(1);
      end
      default: state_d = ERR;
    endcase
    mem_err_d = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

`ifdef HZD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_lu_q, cnt_lu_d, cnt_mw_q, cnt_mw_d, cnt_flush_q, cnt_flush_d;

  always_comb begin
    cnt_lu_d    = cnt_lu_q;
    cnt_mw_d    = cnt_mw_q;
    cnt_flush_d = cnt_flush_q;
    if (r_lu && cnt_lu_q != '1)       cnt_lu_d    = cnt_lu_q + CNT_W'(1);
    if (r_mw && cnt_mw_q != '1)       cnt_mw_d    = cnt_mw_q + CNT_W'(1);
    if (r_br && cnt_flush_q != '1)    cnt_flush_d = cnt_flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_lu_q    <= '0;
      cnt_mw_q    <= '0;
      cnt_flush_q <= '0;
    end else begin
      cnt_lu_q    <= cnt_lu_d;
      cnt_mw_q    <= cnt_mw_d;
      cnt_flush_q <= cnt_flush_d;
    end
  end

  assign cnt_lu    = cnt_lu_q;
  assign cnt_mw    = cnt_mw_q;
  assign cnt_flush = cnt_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_mw.sv
// Self-checking bench for hazard_ctrl_mw: priority-table model checked every negedge
// plus directed literal expectations. Built with WAIT_MAX=4 to reach the timeout quickly.
module tb_hazard_ctrl_mw;
  localparam int WMAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  hazard_ctrl_mw_if #(.REG_AW(5)) hz ();

`ifdef HZD_PERF_CNT_EN
  logic [31:0] cnt_lu, cnt_mw, cnt_flush;
  int m_lu = 0, m_mw = 0, m_fl = 0;
  hazard_ctrl_mw #(.REG_AW(5), .WAIT_MAX(WMAX), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hz(hz),
    .cnt_lu(cnt_lu), .cnt_mw(cnt_mw), .cnt_flush(cnt_flush));
`else
  hazard_ctrl_mw #(.REG_AW(5), .WAIT_MAX(WMAX), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hz(hz));
`endif

  always #5 clk = ~clk;

  // Model state: consecutive memory-wait cycles and the sticky error.
  int run_m = 0;
  bit err_m = 1'b0;

  function automatic logic [6:0] outs_dut();
    return {hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m, hz.flush_d, hz.flush_e, hz.flush_w};
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (hz.reg_write_m && hz.rd_m != 0 && rs == hz.rd_m) return 2'b10;
    if (hz.reg_write_w && hz.rd_w != 0 && rs == hz.rd_w) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_lu_f();
    return hz.is_load_e && hz.reg_write_e && hz.rd_e != 0 &&
           ((hz.rs1_use_d && hz.rs1_d == hz.rd_e) || (hz.rs2_use_d && hz.rs2_d == hz.rd_e));
  endfunction

  function automatic bit m_mw_f();
    return hz.mreq_m && !hz.mem_ready;
  endfunction

  // {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w}
  function automatic logic [6:0] m_outs();
    if (err_m || m_mw_f()) return 7'b1111_001;
    if (hz.pc_src_e)       return 7'b0000_110;
    if (m_lu_f())          return 7'b1100_010;
    return 7'b0000_000;
  endfunction

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  always @(posedge rst) begin
    run_m = 0;
    err_m = 1'b0;
`ifdef HZD_PERF_CNT_EN
    m_lu = 0; m_mw = 0; m_fl = 0;
`endif
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("model_ctl",   {25'd0, outs_dut()}, {25'd0, m_outs()});
      cmp("model_fwd1",  {30'd0, hz.fwd_rs1_e}, {30'd0, m_fwd(hz.rs1_e)});
      cmp("model_fwd2",  {30'd0, hz.fwd_rs2_e}, {30'd0, m_fwd(hz.rs2_e)});
      cmp("model_err",   {31'd0, hz.mem_err}, {31'd0, err_m});
`ifdef HZD_PERF_CNT_EN
      cmp("model_cnt_lu", cnt_lu, m_lu);
      cmp("model_cnt_mw", cnt_mw, m_mw);
      cmp("model_cnt_fl", cnt_flush, m_fl);
`endif
    end
    if (!rst) begin
`ifdef HZD_PERF_CNT_EN
      if (!err_m && m_mw_f())                              m_mw++;
      else if (!err_m && hz.pc_src_e)                      m_fl++;
      else if (!err_m && m_lu_f())                         m_lu++;
`endif
      if (!err_m) begin
        run_m = m_mw_f() ? run_m + 1 : 0;
        if (run_m == WMAX + 1) err_m = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    hz.rs1_d = 0; hz.rs2_d = 0; hz.rs1_e = 0; hz.rs2_e = 0;
    hz.rd_e = 0; hz.rd_m = 0; hz.rd_w = 0;
    hz.rs1_use_d = 0; hz.rs2_use_d = 0;
    hz.reg_write_e = 0; hz.reg_write_m = 0; hz.reg_write_w = 0;
    hz.is_load_e = 0; hz.pc_src_e = 0; hz.mreq_m = 0; hz.mem_ready = 0;
  endtask

  initial begin
    clear_in();
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    #1;
    cmp("rst_ctl", {25'd0, outs_dut()}, 32'h0);
    cmp("rst_fwd", {28'd0, hz.fwd_rs1_e, hz.fwd_rs2_e}, 32'h0);
    cmp("rst_err", {31'd0, hz.mem_err}, 32'h0);

    // Forwarding priority: MEM over WB, x0 never forwards.
    step();
    hz.rs1_e = 5; hz.rs2_e = 5; hz.rd_m = 5; hz.reg_write_m = 1; hz.rd_w = 5; hz.reg_write_w = 1;
    #1 cmp("fwd_mem", {30'd0, hz.fwd_rs1_e}, 32'd2);
    step();
    hz.rd_m = 0;
    #1 cmp("fwd_wb", {30'd0, hz.fwd_rs1_e}, 32'd1);
    step();
    hz.rd_w = 0;
    #1 cmp("fwd_none", {30'd0, hz.fwd_rs1_e}, 32'd0);
    step();
    hz.rs2_e = 9; hz.rd_w = 9; hz.rd_m = 9; hz.reg_write_m = 0;
    #1 cmp("fwd2_wb_mem_we0", {30'd0, hz.fwd_rs2_e}, 32'd1);

    // Load-use.
    step();
    clear_in();
    hz.is_load_e = 1; hz.rd_e = 7; hz.reg_write_e = 1; hz.rs2_d = 7; hz.rs2_use_d = 1;
    #1 cmp("lu_stall", {25'd0, outs_dut()}, 32'b1100_010);
    step();
    hz.rs2_use_d = 0;
    #1 cmp("lu_unused", {25'd0, outs_dut()}, 32'h0);
    step();
    hz.rs1_d = 0; hz.rs1_use_d = 1; hz.rd_e = 0;
    #1 cmp("lu_x0", {25'd0, outs_dut()}, 32'h0);

    // Branch beats load-use.
    step();
    hz.rd_e = 7; hz.rs2_use_d = 1; hz.pc_src_e = 1;
    #1 cmp("br_over_lu", {25'd0, outs_dut()}, 32'b0000_110);

    // Memory wait 3 cycles with pending branch, then release.
    step();
    clear_in();
    hz.mreq_m = 1; hz.pc_src_e = 1;
    for (int i = 0; i < 3; i++) begin
      #1 cmp("mw_freeze", {25'd0, outs_dut()}, 32'b1111_001);
      step();
    end
    hz.mem_ready = 1;
    #1 cmp("mw_release_br", {25'd0, outs_dut()}, 32'b0000_110);
    step();
    clear_in();
    #1 cmp("mw_idle_err", {31'd0, hz.mem_err}, 32'h0);

    // Timeout: error after WAIT_MAX+1 consecutive wait cycles.
    step();
    hz.mreq_m = 1;
    for (int i = 1; i <= WMAX + 1; i++) begin
      step();
      cmp("timeout_err", {31'd0, hz.mem_err}, (i == WMAX + 1) ? 32'd1 : 32'd0);
    end
    hz.mreq_m = 0; hz.pc_src_e = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("err_sticky", {31'd0, hz.mem_err}, 32'd1);
      cmp("err_freeze", {25'd0, outs_dut()}, 32'b1111_001);
    end

    // Asynchronous reset mid-ERR.
    #2 rst = 1'b1;
    #1 cmp("async_rst_err", {31'd0, hz.mem_err}, 32'd0);
    cmp("async_rst_ctl", {25'd0, outs_dut()}, 32'b0000_110);
    step();
    rst = 1'b0;
    clear_in();

    // Wait then rst mid-wait; a fresh wait afterwards must need the full count again.
    hz.mreq_m = 1;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= WMAX; i++) begin
      step();
      cmp("rst_mid_wait", {31'd0, hz.mem_err}, 32'd0);
    end
    hz.mem_ready = 1;
    step();
    cmp("wait_max_no_err", {31'd0, hz.mem_err}, 32'd0);
    clear_in();
    step(); step();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
